// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity-type constants
// and the parity helper used by both the RX and TX halves of the UART.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_rx_state_e;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   // Turns the XOR-reduction of a data word into the parity bit the far end sends
   function automatic logic parityBit(input logic redXor, input logic parTyp);
      return (parTyp == PAR_EVEN) ? redXor : ~redXor;
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Core-side view of the UART receiver: serial line and frame configuration
// going in, received word and status strobes coming out.
interface uart_rx_if #(
   parameter int WIDTH = 8
) ();

   logic             RX_IN;
   logic             PAR_EN;
   logic             PAR_TYP;
   logic [WIDTH-1:0] P_DATA;
   logic             DATA_VALID;
   logic             PAR_ERR;
   logic             STP_ERR;
   logic             Busy;

   // Environment side: drives the line and configuration, consumes results
   modport master (
      output RX_IN, PAR_EN, PAR_TYP,
      input  P_DATA, DATA_VALID, PAR_ERR, STP_ERR, Busy
   );

   // Receiver side
   modport slave (
      input  RX_IN, PAR_EN, PAR_TYP,
      output P_DATA, DATA_VALID, PAR_ERR, STP_ERR, Busy
   );

endinterface

// File: rtl/uart_rx_sampler.sv
// Front end of the UART receiver: brings RX into the clock domain, keeps the
// position inside the current bit and majority-votes three mid-bit samples.
module uart_rx_sampler #(
   parameter int PRESCALE = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        rxIn_i,
   input  logic                        en_i,
   output logic                        syncRx_o,
   output logic [$clog2(PRESCALE)-1:0] edgeCnt_o,
   output logic                        sampledBit_o,
   output logic                        sampleValid_o
);

   localparam int CNT_W = $clog2(PRESCALE);
   localparam int MID   = PRESCALE / 2;

   logic             meta_q;
   logic             sync_q;
   logic [CNT_W-1:0] edgeCnt_q;
   logic             sampleA_q;
   logic             sampleB_q;

   // Two-flop synchronizer; both flops come out of reset at the idle level
   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= rxIn_i;
         sync_q <= meta_q;
      end
   end

   // Bit-phase counter, held at zero while the receiver is idle
   always_ff @(posedge clk) begin
      if (rst || !en_i) begin
         edgeCnt_q <= '0;
      end else if (edgeCnt_q == CNT_W'(PRESCALE - 1)) begin
         edgeCnt_q <= '0;
      end else begin
         edgeCnt_q <= edgeCnt_q + 1'b1;
      end
   end

   // Captures the first two of the three votes; the third is the live line
   always_ff @(posedge clk) begin
      if (rst) begin
         sampleA_q <= 1'b1;
         sampleB_q <= 1'b1;
      end else if (en_i) begin
         if (edgeCnt_q == CNT_W'(MID - 1)) sampleA_q <= sync_q;
         if (edgeCnt_q == CNT_W'(MID))     sampleB_q <= sync_q;
      end
   end

   assign syncRx_o      = sync_q;
   assign edgeCnt_o     = edgeCnt_q;
   assign sampledBit_o  = (sampleA_q & sampleB_q) | (sampleA_q & sync_q) | (sampleB_q & sync_q);
   assign sampleValid_o = en_i && (edgeCnt_q == CNT_W'(MID + 1));

endmodule

// File: rtl/uart_rx_top.sv
// UART receiver: frames start/data/parity/stop bits from the oversampled
// line and reports each frame with a one-cycle strobe.
module uart_rx_top
   import uart_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int PRESCALE = 8
) (
   input  logic     CLK,
   input  logic     RST,
   uart_rx_if.slave bus
);

   localparam int CNT_W = $clog2(PRESCALE);
   localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   uart_rx_state_e   state_q;
   logic [BIT_W-1:0] bitCnt_q;
   logic [WIDTH-1:0] shiftReg_q;
   logic             parEn_q;
   logic             parTyp_q;
   logic             parErrR_q;
   logic             armed_q;
   logic [WIDTH-1:0] pData_q;
   logic             dataValid_q;
   logic             parErr_q;
   logic             stpErr_q;

   logic             syncRx;
   logic [CNT_W-1:0] edgeCnt;
   logic             sampledBit;
   logic             sampleValid;
   logic             bitWrap;

   uart_rx_sampler #(
      .PRESCALE(PRESCALE)
   ) u_sampler (
      .clk          (CLK),
      .rst          (RST),
      .rxIn_i       (bus.RX_IN),
      .en_i         (state_q != IDLE),
      .syncRx_o     (syncRx),
      .edgeCnt_o    (edgeCnt),
      .sampledBit_o (sampledBit),
      .sampleValid_o(sampleValid)
   );

   assign bitWrap = (edgeCnt == CNT_W'(PRESCALE - 1));

   // Frame FSM with registered result/strobe outputs. armed_q blocks a new
   // start until the line has been seen high, so a held-low line (break)
   // yields one errored frame instead of a stream of them.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= IDLE;
         bitCnt_q    <= '0;
         shiftReg_q  <= '0;
         parEn_q     <= 1'b0;
         parTyp_q    <= PAR_EVEN;
         parErrR_q   <= 1'b0;
         armed_q     <= 1'b1;
         pData_q     <= '0;
         dataValid_q <= 1'b0;
         parErr_q    <= 1'b0;
         stpErr_q    <= 1'b0;
      end else begin
         dataValid_q <= 1'b0;
         parErr_q    <= 1'b0;
         stpErr_q    <= 1'b0;
         case (state_q)
            IDLE: begin
               if (syncRx) begin
                  armed_q <= 1'b1;
               end else if (armed_q) begin
                  state_q   <= START;
                  parEn_q   <= bus.PAR_EN;
                  parTyp_q  <= bus.PAR_TYP;
                  bitCnt_q  <= '0;
                  parErrR_q <= 1'b0;
               end
            end
            START: begin
               if (sampleValid && sampledBit) begin
                  state_q <= IDLE;
               end else if (bitWrap) begin
                  state_q <= DATA;
               end
            end
            DATA: begin
               if (sampleValid) begin
                  shiftReg_q <= {sampledBit, shiftReg_q[WIDTH-1:1]};
               end
               if (bitWrap) begin
                  if (bitCnt_q == BIT_W'(WIDTH - 1)) begin
                     bitCnt_q <= '0;
                     state_q  <= parEn_q ? PARITY : STOP;
                  end else begin
                     bitCnt_q <= bitCnt_q + 1'b1;
                  end
               end
            end
            PARITY: begin
               if (sampleValid) begin
                  parErrR_q <= (sampledBit != parityBit(^shiftReg_q, parTyp_q));
               end
               if (bitWrap) begin
                  state_q <= STOP;
               end
            end
            STOP: begin
               if (sampleValid) begin
                  state_q     <= IDLE;
                  armed_q     <= sampledBit;
                  pData_q     <= shiftReg_q;
                  parErr_q    <= parErrR_q;
                  stpErr_q    <= ~sampledBit;
                  dataValid_q <= ~parErrR_q & sampledBit;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.P_DATA     = pData_q;
   assign bus.DATA_VALID = dataValid_q;
   assign bus.PAR_ERR    = parErr_q;
   assign bus.STP_ERR    = stpErr_q;
   assign bus.Busy       = (state_q != IDLE);

endmodule
